// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR flip-flop bank controller.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Counter only has to reach PULSE_CYC-1, so a 1-cycle pulse still gets a 1-bit counter.
    function automatic int pulse_cnt_w(input int pulse_cyc);
        return (pulse_cyc > 1) ? $clog2(pulse_cyc) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer wins.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic             o_valid
);

    logic [PTR_W-1:0] w_pos;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_pos = PTR_W'((int'(i_ptr) + off) % NREQ);
            if (!o_valid && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Arbitrates set/clear requests onto a bank of gated SR flip-flops and
// sequences setup, gate pulse, hold and readback check for each one.
module sr_bank_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int NLATCH    = 8,
    parameter  int PULSE_CYC = 2,
    localparam int IDX_W     = (NLATCH > 1) ? $clog2(NLATCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*IDX_W-1:0] req_idx,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  done_err,
    output logic                  busy,
    output logic [NLATCH-1:0]     lat_s,
    output logic [NLATCH-1:0]     lat_r,
    output logic [NLATCH-1:0]     lat_en,
    input  logic [NLATCH-1:0]     lat_q
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = pulse_cnt_w(PULSE_CYC);

    generate
        if (PULSE_CYC < 1) begin : g_bad_pulse
            $error("sr_bank_ctrl: PULSE_CYC must be at least 1");
        end
    endgenerate

    // Out-of-range indices decode to no latch at all.
    function automatic logic [NLATCH-1:0] idxMask(input logic [IDX_W-1:0] idx);
        return (int'(idx) < NLATCH) ? (NLATCH'(1) << idx) : '0;
    endfunction

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
    logic               r_op, w_op_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [NREQ-1:0]    r_owner, w_owner_nxt;

    logic [NREQ-1:0]    w_gnt_nxt, w_done_nxt;
    logic               w_err_nxt, w_busy_nxt;
    logic [NLATCH-1:0]  w_s_nxt, w_r_nxt, w_en_nxt;

    logic [NREQ-1:0]    w_arb_gnt;
    logic               w_arb_valid;
    logic [PTR_W-1:0]   w_win;
    logic               w_win_op;
    logic [IDX_W-1:0]   w_win_idx;
    logic [NLATCH-1:0]  w_win_mask, w_cur_mask, w_q_shift;
    logic               w_in_range;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_win     = '0;
        w_win_op  = 1'b0;
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_gnt[i]) begin
                w_win     = PTR_W'(i);
                w_win_op  = req_op[i];
                w_win_idx = req_idx[i*IDX_W +: IDX_W];
            end
        end
        w_win_mask = idxMask(w_win_idx);
        w_cur_mask = idxMask(r_idx);
        w_in_range = (int'(r_idx) < NLATCH);
        w_q_shift  = lat_q >> r_idx;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_op_nxt    = r_op;
        w_idx_nxt   = r_idx;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_s_nxt     = lat_s;
        w_r_nxt     = lat_r;
        w_en_nxt    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt = SETUP;
                    w_gnt_nxt   = w_arb_gnt;
                    w_owner_nxt = w_arb_gnt;
                    w_op_nxt    = w_win_op;
                    w_idx_nxt   = w_win_idx;
                    w_ptr_nxt   = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
                    w_s_nxt     = (w_win_op == OP_SET) ? w_win_mask : '0;
                    w_r_nxt     = (w_win_op == OP_CLR) ? w_win_mask : '0;
                end
            end
            SETUP: begin
                w_state_nxt = PULSE;
                w_cnt_nxt   = CNT_W'(PULSE_CYC - 1);
                w_en_nxt    = w_cur_mask;
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    w_en_nxt  = w_cur_mask;
                end
            end
            HOLD: begin
                w_state_nxt = CHECK;
                w_s_nxt     = '0;
                w_r_nxt     = '0;
                w_done_nxt  = r_owner;
                w_err_nxt   = !w_in_range || (w_q_shift[0] != r_op);
            end
            CHECK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_s_nxt     = '0;
                w_r_nxt     = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_owner  <= '0;
            gnt      <= '0;
            done     <= '0;
            done_err <= 1'b0;
            busy     <= 1'b0;
            lat_s    <= '0;
            lat_r    <= '0;
            lat_en   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_op     <= w_op_nxt;
            r_idx    <= w_idx_nxt;
            r_owner  <= w_owner_nxt;
            gnt      <= w_gnt_nxt;
            done     <= w_done_nxt;
            done_err <= w_err_nxt;
            busy     <= w_busy_nxt;
            lat_s    <= w_s_nxt;
            lat_r    <= w_r_nxt;
            lat_en   <= w_en_nxt;
        end
    end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Directed bench for sr_bank_ctrl with a behavioural SR latch bank and a
// second build (NLATCH=6) for the out-of-range index case.
module tb_sr_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, reqOp, gnt, done;
    logic [11:0] reqIdx;
    logic        doneErr, busy;
    logic [7:0]  latS, latR, latEn, latQ;

    logic [3:0]  req6, reqOp6, gnt6, done6;
    logic [11:0] reqIdx6;
    logic        doneErr6, busy6;
    logic [5:0]  latS6, latR6, latEn6, latQ6;

    logic [7:0]  qBank = '0;
    logic [7:0]  stuckMask;
    logic [7:0]  prevS, prevR;
    int          nChecks = 0;
    int          nFail = 0;

    always #5 clk = ~clk;

    sr_bank_ctrl #(.NREQ(4), .NLATCH(8), .PULSE_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_op(reqOp), .req_idx(reqIdx),
        .gnt(gnt), .done(done), .done_err(doneErr), .busy(busy),
        .lat_s(latS), .lat_r(latR), .lat_en(latEn), .lat_q(latQ)
    );

    sr_bank_ctrl #(.NREQ(4), .NLATCH(6), .PULSE_CYC(2)) u_dut6 (
        .clk(clk), .rst(rst), .req(req6), .req_op(reqOp6), .req_idx(reqIdx6),
        .gnt(gnt6), .done(done6), .done_err(doneErr6), .busy(busy6),
        .lat_s(latS6), .lat_r(latR6), .lat_en(latEn6), .lat_q(latQ6)
    );

    // Gated SR bank: while the gate is high, s sets and r clears; stuck bits read 0.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (latEn[i]) begin
                if (latS[i])      qBank[i] <= 1'b1;
                else if (latR[i]) qBank[i] <= 1'b0;
            end
        end
    end
    assign latQ  = qBank & ~stuckMask;
    assign latQ6 = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int n, input logic op, input int idx);
        req    = 4'(1 << n);
        reqOp  = 4'(op) << n;
        reqIdx = 12'(idx) << (n * 3);
    endtask

    // One full operation from requester n; expected latch patterns supplied by the caller.
    task automatic runOp(input string tag, input int n, input logic op, input int idx,
                         input logic [7:0] expS, input logic [7:0] expR,
                         input logic [7:0] expEn, input logic expErr);
        logic [3:0] expG;
        expG = 4'(1 << n);
        applyStimulus(n, op, idx);
        tick();
        checkOutput({tag, " gnt"}, 32'(gnt), 32'(expG));
        checkOutput({tag, " setup s"}, 32'(latS), 32'(expS));
        checkOutput({tag, " setup r"}, 32'(latR), 32'(expR));
        checkOutput({tag, " setup en"}, 32'(latEn), 32'h0);
        checkOutput({tag, " busy"}, 32'(busy), 32'h1);
        req = '0;
        tick();
        checkOutput({tag, " gnt pulse"}, 32'(gnt), 32'h0);
        checkOutput({tag, " pulse1 en"}, 32'(latEn), 32'(expEn));
        tick();
        checkOutput({tag, " pulse2 en"}, 32'(latEn), 32'(expEn));
        tick();
        checkOutput({tag, " hold en"}, 32'(latEn), 32'h0);
        checkOutput({tag, " hold s"}, 32'(latS), 32'(expS));
        checkOutput({tag, " hold r"}, 32'(latR), 32'(expR));
        tick();
        checkOutput({tag, " done"}, 32'(done), 32'(expG));
        checkOutput({tag, " done_err"}, 32'(doneErr), 32'(expErr));
        checkOutput({tag, " check s|r"}, 32'(latS | latR), 32'h0);
        tick();
        checkOutput({tag, " done clear"}, 32'(done), 32'h0);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'hF; reqOp = 4'hF; reqIdx = '0;
        req6 = '0; reqOp6 = '0; reqIdx6 = '0;
        stuckMask = '0;

        repeat (3) begin
            tick();
            checkOutput("reset gnt", 32'(gnt), 32'h0);
            checkOutput("reset done", 32'({done, doneErr, busy}), 32'h0);
            checkOutput("reset lat", 32'({latS, latR, latEn}), 32'h0);
        end
        req = '0;
        rst = 1'b0;
        tick();

        runOp("set3", 0, 1'b1, 3, 8'h08, 8'h00, 8'h08, 1'b0);
        runOp("clr3", 1, 1'b0, 3, 8'h00, 8'h08, 8'h08, 1'b0);
        stuckMask = 8'h20;
        runOp("stuck5", 2, 1'b1, 5, 8'h20, 8'h00, 8'h20, 1'b1);
        stuckMask = '0;

        // Pointer is now 3; requester 2 alone wins, leaving the pointer at 3 again.
        applyStimulus(2, 1'b1, 0);
        tick();
        checkOutput("midrst gnt", 32'(gnt), 32'h4);
        req = '0;
        tick();
        checkOutput("midrst pulse en", 32'(latEn), 32'h01);
        rst = 1'b1;
        tick();
        checkOutput("midrst outs", 32'({gnt, done, doneErr, busy}), 32'h0);
        checkOutput("midrst lat", 32'({latS, latR, latEn}), 32'h0);
        rst = 1'b0;
        repeat (6) begin
            tick();
            checkOutput("midrst no done", 32'({done, busy}), 32'h0);
        end
        req = 4'b1100; reqOp = 4'b1100; reqIdx = 12'h280;
        tick();
        checkOutput("ptr restart gnt", 32'(gnt), 32'h4);
        req = '0;
        repeat (5) tick();
        checkOutput("ptr restart idle", 32'(busy), 32'h0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'hF; reqOp = 4'hF; reqIdx = 12'h688;
        tick();
        checkOutput("rr gnt0", 32'(gnt), 32'h1);
        for (int i = 1; i < 4; i++) begin
            repeat (5) tick();
            checkOutput("rr gap busy", 32'({gnt, busy}), 32'h0);
            tick();
            checkOutput("rr gnt", 32'(gnt), 32'(1 << i));
        end
        req = 4'b0101;
        repeat (6) tick();
        checkOutput("rr 0101 first", 32'(gnt), 32'h1);
        repeat (6) tick();
        checkOutput("rr 0101 second", 32'(gnt), 32'h4);
        req = '0;
        repeat (6) tick();

        req6 = 4'b0001; reqOp6 = 4'b0001; reqIdx6 = 12'h007;
        tick();
        checkOutput("oob gnt", 32'(gnt6), 32'h1);
        checkOutput("oob setup lat", 32'({latS6, latR6}), 32'h0);
        req6 = '0;
        tick();
        checkOutput("oob pulse en", 32'(latEn6), 32'h0);
        repeat (3) tick();
        checkOutput("oob done", 32'(done6), 32'h1);
        checkOutput("oob done_err", 32'(doneErr6), 32'h1);
        tick();

        // Random traffic with the bank invariants checked every cycle.
        prevS = latS;
        prevR = latR;
        repeat (3000) begin
            req    = 4'($urandom_range(0, 15));
            reqOp  = 4'($urandom);
            reqIdx = 12'($urandom);
            tick();
            checkOutput("inv en onehot", 32'($onehot0(latEn)), 32'h1);
            checkOutput("inv s&r", 32'(latS & latR), 32'h0);
            checkOutput("inv gnt/done onehot", 32'({$onehot0(gnt), $onehot0(done)}), 32'h3);
            if (latEn != '0) begin
                checkOutput("inv s/r stable", 32'({latS, latR}), 32'({prevS, prevR}));
            end
            prevS = latS;
            prevR = latR;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
